// File: rtl/game_if.sv
// game_if: player/timing inputs and display-facing outputs of game_engine.
//   Inputs to the engine : start, tick, press_valid, press_idx[3:0]
//   Outputs to display   : game_state[1:0], fire_state[8:0], gold_state[8:0],
//                          warning_state[8:0], box[8:0], life[1:0], score[3:0]
//   master : the side that drives start/tick/presses and observes the game
//   slave  : game_engine itself
interface game_if;
  logic       start;
  logic       tick;
  logic       press_valid;
  logic [3:0] press_idx;
  logic [1:0] game_state;
  logic [8:0] fire_state;
  logic [8:0] gold_state;
  logic [8:0] warning_state;
  logic [8:0] box;
  logic [1:0] life;
  logic [3:0] score;

  modport master (
    output start, tick, press_valid, press_idx,
    input  game_state, fire_state, gold_state, warning_state, box, life, score
  );

  modport slave (
    input  start, tick, press_valid, press_idx,
    output game_state, fire_state, gold_state, warning_state, box, life, score
  );
endinterface

// File: rtl/game_engine.sv
// game_engine: game-state generator for the 3x3 fire/gold grid game.
// Owns the INIT/PLAY/FINISH flow, nine per-cell hazard FSMs with countdowns,
// LFSR-driven spawning, the press highlight, and the life/score counters.
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : game_if.slave
//          in  start, tick, press_valid, press_idx (0..8, row-major y*3+x)
//          out game_state (00 INIT, 01 PLAY, 10 FINISH), fire_state,
//              gold_state, warning_state, box, life, score
//
// Build option:
//   GAME_WARNING_EN  defined   -> fire spawns pass through WARN for WARN_TICKS
//                               ticks and warning_state is driven.
//                    undefined -> fire spawns enter FIRE directly and
//                               warning_state is tied to zero.
module game_engine #(
  parameter int         SPAWN_PERIOD = 4,
  parameter int         WARN_TICKS   = 3,
  parameter int         FIRE_TICKS   = 6,
  parameter int         GOLD_TICKS   = 5,
  parameter int         BOX_TICKS    = 2,
  parameter int         LIFE_MAX     = 3,
  parameter int         SCORE_MAX    = 5,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic   clk,
  input  logic   rst,
  game_if.slave  bus
);

  localparam int NCELL = 9;

  typedef enum logic [1:0] {
    GS_INIT   = 2'b00,
    GS_PLAY   = 2'b01,
    GS_FINISH = 2'b10
  } game_st_e;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_WARN = 2'd1,
    C_FIRE = 2'd2,
    C_GOLD = 2'd3
  } cell_st_e;

`ifdef GAME_WARNING_EN
  localparam cell_st_e HAZARD_ST = C_WARN;
`else
  localparam cell_st_e HAZARD_ST = C_FIRE;
`endif

  localparam logic [3:0] SPAWN_LAST = 4'(SPAWN_PERIOD - 1);
  localparam logic [3:0] BOX_CNT    = 4'(BOX_TICKS);
  localparam logic [1:0] LIFE_INIT  = 2'(LIFE_MAX);
  localparam logic [3:0] SCORE_LIM  = 4'(SCORE_MAX);

  // Galois form of x^8+x^6+x^5+x^4+1 (right shift, toggle mask 0xB8).
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    lfsr_next = {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction

  // Countdown loaded when a cell enters the given state.
  function automatic logic [3:0] reload_cnt(input cell_st_e s);
    case (s)
      C_WARN:  reload_cnt = 4'(WARN_TICKS);
      C_FIRE:  reload_cnt = 4'(FIRE_TICKS);
      C_GOLD:  reload_cnt = 4'(GOLD_TICKS);
      default: reload_cnt = 4'd0;
    endcase
  endfunction

  // Life minus expired fires, floored at zero.
  function automatic logic [1:0] life_sat_sub(input logic [1:0] l, input logic [3:0] n);
    if ({2'b00, l} <= n) life_sat_sub = 2'd0;
    else                 life_sat_sub = l - n[1:0];
  endfunction

  // Score plus one, capped at the winning score.
  function automatic logic [3:0] score_sat_inc(input logic [3:0] s);
    if (s >= SCORE_LIM) score_sat_inc = SCORE_LIM;
    else                score_sat_inc = s + 4'd1;
  endfunction

  game_st_e   game_q,    game_d;
  cell_st_e   cell_q    [NCELL];
  cell_st_e   cell_d    [NCELL];
  logic [3:0] cnt_q     [NCELL];
  logic [3:0] cnt_d     [NCELL];
  logic [7:0] lfsr_q,    lfsr_d;
  logic [3:0] spawn_q,   spawn_d;
  logic [8:0] box_q,     box_d;
  logic [3:0] box_cnt_q, box_cnt_d;
  logic [1:0] life_q,    life_d;
  logic [3:0] score_q,   score_d;

  logic       press_ok;
  logic [8:0] press_oh;
  logic       spawn_go;
  logic       gold_hit;
  logic       clear_grid;
  logic       terminal;
  logic [3:0] lost;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      game_q    <= GS_INIT;
      lfsr_q    <= LFSR_SEED;
      spawn_q   <= '0;
      box_q     <= '0;
      box_cnt_q <= '0;
      life_q    <= '0;
      score_q   <= '0;
      for (int i = 0; i < NCELL; i++) begin
        cell_q[i] <= C_IDLE;
        cnt_q[i]  <= '0;
      end
    end else begin
      game_q    <= game_d;
      lfsr_q    <= lfsr_d;
      spawn_q   <= spawn_d;
      box_q     <= box_d;
      box_cnt_q <= box_cnt_d;
      life_q    <= life_d;
      score_q   <= score_d;
      for (int i = 0; i < NCELL; i++) begin
        cell_q[i] <= cell_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  always_comb begin
    game_d    = game_q;
    lfsr_d    = lfsr_q;
    spawn_d   = spawn_q;
    box_d     = box_q;
    box_cnt_d = box_cnt_q;
    life_d    = life_q;
    score_d   = score_q;
    for (int i = 0; i < NCELL; i++) begin
      cell_d[i] = cell_q[i];
      cnt_d[i]  = cnt_q[i];
    end
    spawn_go   = 1'b0;
    gold_hit   = 1'b0;
    clear_grid = 1'b0;
    lost       = '0;
    press_ok   = bus.press_valid && (bus.press_idx <= 4'd8);
    press_oh   = press_ok ? (9'd1 << bus.press_idx) : 9'd0;
    // Game end is judged on registered counters, one cycle after they land.
    terminal   = (life_q == 2'd0) || (score_q >= SCORE_LIM);

    // The LFSR free-runs on tick regardless of game state.
    if (bus.tick) lfsr_d = lfsr_next(lfsr_q);

    unique case (game_q)
      GS_INIT: begin
        clear_grid = 1'b1;
        if (bus.start) begin
          life_d  = LIFE_INIT;
          score_d = '0;
          game_d  = GS_PLAY;
        end
      end

      GS_PLAY: begin
        if (terminal) begin
          // Everything freezes from here; FINISH holds the last picture.
          game_d = GS_FINISH;
        end else begin
          if (bus.tick) begin
            if (spawn_q == SPAWN_LAST) begin
              spawn_d  = '0;
              spawn_go = 1'b1;
            end else begin
              spawn_d = spawn_q + 4'd1;
            end
          end

          for (int i = 0; i < NCELL; i++) begin
            // A press that clears a cell overrides that cell's countdown, so
            // a fire pressed on its expiry tick costs no life.
            if (press_oh[i] && cell_q[i] == C_FIRE) begin
              cell_d[i] = C_IDLE;
              cnt_d[i]  = '0;
            end else if (press_oh[i] && cell_q[i] == C_GOLD) begin
              cell_d[i] = C_IDLE;
              cnt_d[i]  = '0;
              gold_hit  = 1'b1;
            end else if (bus.tick && cell_q[i] != C_IDLE) begin
              if (cnt_q[i] == 4'd1) begin
                case (cell_q[i])
                  C_WARN: begin
                    cell_d[i] = C_FIRE;
                    cnt_d[i]  = reload_cnt(C_FIRE);
                  end
                  C_FIRE: begin
                    cell_d[i] = C_IDLE;
                    cnt_d[i]  = '0;
                    lost      = lost + 4'd1;
                  end
                  default: begin
                    cell_d[i] = C_IDLE;
                    cnt_d[i]  = '0;
                  end
                endcase
              end else begin
                cnt_d[i] = cnt_q[i] - 4'd1;
              end
            end

            // Spawn checks the pre-update state; candidates 9..15 never match.
            if (spawn_go && lfsr_q[3:0] == 4'(i) && cell_q[i] == C_IDLE) begin
              cell_d[i] = lfsr_q[4] ? C_GOLD : HAZARD_ST;
              cnt_d[i]  = reload_cnt(lfsr_q[4] ? C_GOLD : HAZARD_ST);
            end
          end

          life_d = life_sat_sub(life_q, lost);
          if (gold_hit) score_d = score_sat_inc(score_q);

          if (press_ok) begin
            box_d     = press_oh;
            box_cnt_d = BOX_CNT;
          end else if (bus.tick && box_cnt_q != 4'd0) begin
            box_cnt_d = box_cnt_q - 4'd1;
            if (box_cnt_q == 4'd1) box_d = '0;
          end
        end
      end

      GS_FINISH: begin
        if (bus.start) begin
          game_d     = GS_INIT;
          clear_grid = 1'b1;
        end
      end

      default: begin
        game_d     = GS_INIT;
        clear_grid = 1'b1;
      end
    endcase

    if (clear_grid) begin
      for (int i = 0; i < NCELL; i++) begin
        cell_d[i] = C_IDLE;
        cnt_d[i]  = '0;
      end
      box_d     = '0;
      box_cnt_d = '0;
      spawn_d   = '0;
    end
  end

  logic [8:0] fire_vec;
  logic [8:0] gold_vec;
  logic [8:0] warn_vec;

  always_comb begin
    fire_vec = '0;
    gold_vec = '0;
    warn_vec = '0;
    for (int i = 0; i < NCELL; i++) begin
      fire_vec[i] = (cell_q[i] == C_FIRE);
      gold_vec[i] = (cell_q[i] == C_GOLD);
`ifdef GAME_WARNING_EN
      warn_vec[i] = (cell_q[i] == C_WARN);
`endif
    end
  end

  assign bus.game_state    = game_q;
  assign bus.fire_state    = fire_vec;
  assign bus.gold_state    = gold_vec;
  assign bus.warning_state = warn_vec;
  assign bus.box           = box_q;
  assign bus.life          = life_q;
  assign bus.score         = score_q;

endmodule

// File: tb/tb_game_engine.sv
// tb_game_engine: scoreboard bench for game_engine. A behavioural game model
// is stepped with every driven cycle; its predicted outputs are queued and
// compared against the DUT one cycle later. Stimulus steers the model-known
// grid to reach winning, losing, press-on-expiry and reset-mid-game cases.
module tb_game_engine;

  localparam int SPAWN_PERIOD = 4;
  localparam int WARN_TICKS   = 3;
  localparam int FIRE_TICKS   = 6;
  localparam int GOLD_TICKS   = 5;
  localparam int BOX_TICKS    = 2;
  localparam int LIFE_MAX     = 3;
  localparam int SCORE_MAX    = 5;
  localparam logic [7:0] SEED = 8'hA5;

  localparam int S_IDLE = 0, S_WARN = 1, S_FIRE = 2, S_GOLD = 3;
  localparam int G_INIT = 0, G_PLAY = 1, G_FINISH = 2;

  typedef struct {
    logic [1:0] gs;
    logic [8:0] fire;
    logic [8:0] gold;
    logic [8:0] warn;
    logic [8:0] box;
    logic [1:0] life;
    logic [3:0] score;
  } exp_t;

  logic clk;
  logic rst;
  game_if gif ();

  game_engine #(
    .SPAWN_PERIOD(SPAWN_PERIOD), .WARN_TICKS(WARN_TICKS), .FIRE_TICKS(FIRE_TICKS),
    .GOLD_TICKS(GOLD_TICKS), .BOX_TICKS(BOX_TICKS), .LIFE_MAX(LIFE_MAX),
    .SCORE_MAX(SCORE_MAX), .LFSR_SEED(SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (gif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_gs;
  int         m_st  [9];
  int         m_cnt [9];
  logic [8:0] m_box;
  int         m_boxcnt;
  int         m_life;
  int         m_score;
  logic [7:0] m_lfsr;
  int         m_spawn;
  int         m_step_lost;
  int         m_exp_cell;

  exp_t sbq[$];

  task automatic model_clear();
    for (int i = 0; i < 9; i++) begin
      m_st[i]  = S_IDLE;
      m_cnt[i] = 0;
    end
    m_box    = '0;
    m_boxcnt = 0;
    m_spawn  = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_gs    = G_INIT;
    m_life  = 0;
    m_score = 0;
    m_lfsr  = SEED;
  endtask

  task automatic model_step(input logic st, input logic tk, input logic pv, input logic [3:0] pi);
    logic [7:0] pre;
    int old [9];
    int lost;
    int cand;
    bit got;
    bit att;
    pre  = m_lfsr;
    lost = 0;
    got  = 0;
    att  = 0;
    m_step_lost = 0;
    if (tk) begin
      m_lfsr = {pre[0], pre[7], pre[6] ^ pre[0], pre[5] ^ pre[0], pre[4] ^ pre[0],
                pre[3], pre[2], pre[1]};
    end
    if (m_gs == G_INIT) begin
      model_clear();
      if (st) begin
        m_life  = LIFE_MAX;
        m_score = 0;
        m_gs    = G_PLAY;
      end
    end else if (m_gs == G_FINISH) begin
      if (st) begin
        m_gs = G_INIT;
        model_clear();
      end
    end else if (m_life == 0 || m_score >= SCORE_MAX) begin
      m_gs = G_FINISH;
    end else begin
      for (int i = 0; i < 9; i++) old[i] = m_st[i];
      if (tk) begin
        if (m_spawn == SPAWN_PERIOD - 1) begin
          m_spawn = 0;
          att     = 1;
        end else begin
          m_spawn++;
        end
      end
      for (int i = 0; i < 9; i++) begin
        if (pv && int'(pi) == i && old[i] == S_FIRE) begin
          m_st[i] = S_IDLE; m_cnt[i] = 0;
        end else if (pv && int'(pi) == i && old[i] == S_GOLD) begin
          m_st[i] = S_IDLE; m_cnt[i] = 0; got = 1;
        end else if (tk && old[i] != S_IDLE) begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) begin
            if (old[i] == S_WARN) begin
              m_st[i] = S_FIRE; m_cnt[i] = FIRE_TICKS;
            end else begin
              if (old[i] == S_FIRE) begin
                lost++;
                m_exp_cell = i;
              end
              m_st[i] = S_IDLE;
            end
          end
        end
      end
      cand = int'(pre[3:0]);
      if (att && cand < 9) begin
        if (old[cand] == S_IDLE) begin
          if (pre[4]) begin
            m_st[cand] = S_GOLD; m_cnt[cand] = GOLD_TICKS;
          end else begin
`ifdef GAME_WARNING_EN
            m_st[cand] = S_WARN; m_cnt[cand] = WARN_TICKS;
`else
            m_st[cand] = S_FIRE; m_cnt[cand] = FIRE_TICKS;
`endif
          end
        end
      end
      m_step_lost = lost;
      m_life = (lost >= m_life) ? 0 : m_life - lost;
      if (got) m_score = (m_score + 1 > SCORE_MAX) ? SCORE_MAX : m_score + 1;
      if (pv && pi < 4'd9) begin
        m_box    = 9'd1 << pi;
        m_boxcnt = BOX_TICKS;
      end else if (tk && m_boxcnt > 0) begin
        m_boxcnt--;
        if (m_boxcnt == 0) m_box = '0;
      end
    end
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.gs   = 2'(m_gs);
    e.fire = '0;
    e.gold = '0;
    e.warn = '0;
    for (int i = 0; i < 9; i++) begin
      e.fire[i] = (m_st[i] == S_FIRE);
      e.gold[i] = (m_st[i] == S_GOLD);
      e.warn[i] = (m_st[i] == S_WARN);
    end
    e.box   = m_box;
    e.life  = 2'(m_life);
    e.score = 4'(m_score);
    return e;
  endfunction

  // ---------------- drive / sample ----------------
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk_eq("game_state",    32'(gif.game_state),    32'(e.gs));
      chk_eq("fire_state",    32'(gif.fire_state),    32'(e.fire));
      chk_eq("gold_state",    32'(gif.gold_state),    32'(e.gold));
      chk_eq("warning_state", 32'(gif.warning_state), 32'(e.warn));
      chk_eq("box",           32'(gif.box),           32'(e.box));
      chk_eq("life",          32'(gif.life),          32'(e.life));
      chk_eq("score",         32'(gif.score),         32'(e.score));
    end
  endtask

  task automatic drive(input logic st, input logic tk, input logic pv, input logic [3:0] pi);
    gif.start       = st;
    gif.tick        = tk;
    gif.press_valid = pv;
    gif.press_idx   = pi;
    model_step(st, tk, pv, pi);
    sbq.push_back(model_outputs());
  endtask

  task automatic cyc(input logic st, input logic tk, input logic pv, input logic [3:0] pi);
    sample();
    drive(st, tk, pv, pi);
  endtask

  task automatic do_reset();
    sample();
    gif.start = 1'b0; gif.tick = 1'b0; gif.press_valid = 1'b0; gif.press_idx = 4'd0;
    #1 rst = 1'b1;
    #1;
    chk_eq("rst_game_state", 32'(gif.game_state),    32'd0);
    chk_eq("rst_fire",       32'(gif.fire_state),    32'd0);
    chk_eq("rst_gold",       32'(gif.gold_state),    32'd0);
    chk_eq("rst_warn",       32'(gif.warning_state), 32'd0);
    chk_eq("rst_box",        32'(gif.box),           32'd0);
    chk_eq("rst_life",       32'(gif.life),          32'd0);
    chk_eq("rst_score",      32'(gif.score),         32'd0);
    #1 rst = 1'b0;
    sbq.delete();
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  // ---------------- game runner ----------------
  bit pend_simul = 0;
  int pend_cell  = 0;
  int pend_life  = 0;
  bit pend_loss  = 0;
  int loss_cell  = 0;
  bit loss_seen  = 0;

  task automatic pending_checks();
    if (pend_simul) begin
      chk_eq("press_on_expiry_life", 32'(gif.life), 32'(pend_life));
      chk_eq("press_on_expiry_fire", 32'(gif.fire_state[pend_cell]), 32'd0);
      pend_simul = 0;
    end
    if (pend_loss) begin
      chk_eq("first_loss_life", 32'(gif.life), 32'(LIFE_MAX - 1));
      chk_eq("first_loss_fire", 32'(gif.fire_state[loss_cell]), 32'd0);
      pend_loss = 0;
    end
  endtask

  // collect=1: grab every gold and press each fire on its expiry tick.
  // collect=0: leave the grid alone apart from stray presses.
  task automatic run_game(input bit collect);
    int   n;
    logic tk, st, pv;
    logic [3:0] pi;
    bit   simul;
    int   life_b;
    n = 0;
    while (m_gs == G_PLAY && n < 4000) begin
      sample();
      pending_checks();
      tk = (n % 3 == 0);
      st = (n % 11 == 5);
      pv = 1'b0;
      pi = 4'd0;
      simul = 0;
      if (collect && m_life > 0 && m_score < SCORE_MAX) begin
        for (int i = 0; i < 9; i++)
          if (!pv && tk && m_st[i] == S_FIRE && m_cnt[i] == 1) begin
            pv = 1'b1; pi = 4'(i); simul = 1;
          end
        for (int i = 0; i < 9; i++)
          if (!pv && m_st[i] == S_GOLD) begin
            pv = 1'b1; pi = 4'(i);
          end
      end
      if (!pv && (n % 7 == 3)) begin
        pv = 1'b1;
        pi = 4'($urandom_range(0, 15));
      end
      life_b = m_life;
      drive(st, tk, pv, pi);
      if (simul) begin
        pend_simul = 1; pend_cell = int'(pi); pend_life = life_b;
      end
      if (!loss_seen && life_b == LIFE_MAX && m_step_lost > 0) begin
        pend_loss = 1; loss_cell = m_exp_cell; loss_seen = 1;
      end
      n++;
    end
    if (n >= 4000) chk_eq("game_timeout", 32'd1, 32'd0);
    sample();
    pending_checks();
  endtask

  task automatic start_game();
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    sample();
    chk_eq("start_game_state", 32'(gif.game_state), 32'd1);
    chk_eq("start_life",       32'(gif.life),       32'(LIFE_MAX));
    chk_eq("start_score",      32'(gif.score),      32'd0);
    chk_eq("start_grid",       32'(gif.fire_state | gif.gold_state | gif.warning_state | gif.box), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    gif.start = 1'b0; gif.tick = 1'b0; gif.press_valid = 1'b0; gif.press_idx = 4'd0;
    model_reset();
    do_reset();

    // INIT: ticks and presses leave the grid untouched
    for (int n = 0; n < 6; n++) cyc(1'b0, 1'(n % 2), 1'b1, 4'(n));
    sample();
    start_game();

    // Winning game
    run_game(1'b1);
    chk_eq("win_game_state", 32'(gif.game_state), 32'd2);
    chk_eq("win_score",      32'(gif.score),      32'(SCORE_MAX));
    // FINISH: grid frozen under presses and ticks
    for (int n = 0; n < 9; n++) cyc(1'b0, 1'(n % 2), 1'b1, 4'(n));
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    sample();
    chk_eq("finish_to_init_state", 32'(gif.game_state), 32'd0);
    chk_eq("finish_to_init_grid",  32'(gif.fire_state | gif.gold_state | gif.box), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    sample();

    // Losing game
    start_game();
    run_game(1'b0);
    chk_eq("lose_game_state", 32'(gif.game_state), 32'd2);
    chk_eq("lose_life",       32'(gif.life),       32'd0);
    chk_eq("lose_first_loss_seen", 32'(loss_seen), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    sample();
    chk_eq("lose_to_init_grid", 32'(gif.fire_state | gif.gold_state | gif.box), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    sample();

    // Reset in the middle of play
    start_game();
    for (int n = 0; n < 40; n++) cyc(1'b0, 1'(n % 2 == 0), 1'(n % 5 == 1), 4'(n % 10));
    do_reset();
    sample();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/game_engine.md
# game_engine

Game-state generator for the 3x3 fire/gold grid game. It owns the game flow (INIT/PLAY/FINISH), per-cell hazard lifetimes, pseudo-random spawning, the player highlight, and the life and score counters. The display controller reads `game_state`, `fire_state`, `gold_state`, `warning_state`, `box`, `life` and `score` directly from this block. Player presses come from the keypad decoder, and `tick` comes from the shared game-rate divider.

## Interface
- `SPAWN_PERIOD`, 4: number of ticks between spawn attempts.
- `WARN_TICKS`, 3: duration of the WARN phase, in ticks.
- `FIRE_TICKS`, 6: time a fire stays lit before it costs a life, in ticks.
- `GOLD_TICKS`, 5: lifetime of a gold cell, in ticks.
- `BOX_TICKS`, 2: time the highlight on the last pressed cell persists, in ticks.
- `LIFE_MAX`, 3: starting life.
- `SCORE_MAX`, 5: winning score.
- `LFSR_SEED`, 8'hA5: LFSR reset value. Must be nonzero.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: single-cycle pulse. Advances INIT to PLAY and FINISH to INIT.
- `tick` in 1: single-cycle game-rate enable.
- `press_valid` in 1: single-cycle press strobe.
- `press_idx` in 4: pressed cell, 0..8, row-major (`y*3+x`).
- `game_state` out 2: 00 INIT, 01 PLAY, 10 FINISH.
- `fire_state` out 9: one-hot-per-cell, cell is in FIRE.
- `gold_state` out 9: cell is in GOLD.
- `warning_state` out 9: cell is in WARN.
- `box` out 9: highlight on the last pressed cell.
- `life` out 2: remaining life.
- `score` out 4: current score.

## Operation
- **Per-cell FSM.** There are nine independent cells, each with states IDLE, WARN, FIRE and GOLD plus a 4-bit countdown. The `fire_state`, `gold_state` and `warning_state` bit for each cell is a direct decode of that cell's state.
- **LFSR.** 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1. It advances only on `tick`, in every game state.
- **Spawn attempt.** In PLAY, a spawn counter counts ticks. On the tick where the counter reaches `SPAWN_PERIOD-1`, it wraps to 0 and a spawn is attempted:
  - The candidate cell is `lfsr[3:0]`, using the pre-advance LFSR value.
  - The spawn is skipped if the candidate is 9 or greater, or if the cell is not IDLE.
  - If `lfsr[4]`=1, the cell enters GOLD with countdown `GOLD_TICKS`.
  - Otherwise the cell enters WARN with countdown `WARN_TICKS`.
- **Countdown on tick.** On each tick in PLAY, every non-IDLE cell decrements its countdown. When a countdown of 1 is ticked:
  - WARN goes to FIRE with countdown `FIRE_TICKS`.
  - FIRE goes to IDLE and costs one life.
  - GOLD goes to IDLE with no penalty.
- **Press handling.** A press in PLAY with `press_idx` of 8 or less acts on the target cell's current state:
  - FIRE: the cell goes to IDLE.
  - GOLD: the cell goes to IDLE and `score` increments.
  - IDLE or WARN: no effect on the cell.
  - In all cases, `box` becomes one-hot of `press_idx` and its hold counter is loaded with `BOX_TICKS`.
  - `press_idx` of 9 or more is ignored entirely.
- **Highlight hold.** `box` clears when its hold counter expires on a tick.
- **Life loss.** `life` decreases by the number of fires expiring on that tick, saturating at 0.
- **Score.** `score` saturates at `SCORE_MAX`.
- **INIT.** All cell states, `box`, the spawn counter, and countdowns are held at zero. On `start`:
  - `life` is loaded with `LIFE_MAX` and `score` with 0.
  - The state goes to PLAY. The LFSR keeps its current value.
- **PLAY exit.** The state goes to FINISH in the cycle after `life` becomes 0 or `score` becomes `SCORE_MAX`.
- **FINISH.** Cell and `box` outputs are frozen. `start` goes to INIT, which clears the grid.
- `start` in PLAY is ignored.

## Timing
- All outputs are registered. A `press`, `tick` or `start` seen at edge N is reflected at edge N+1.
- Reset values:
  - `game_state`=00.
  - `fire_state`, `gold_state`, `warning_state` and `box` = 0.
  - `life`=0, `score`=0.
  - LFSR=`LFSR_SEED`, spawn counter=0.
- **Press and tick on the same cycle, same cell.** The press wins. An expiring fire costs no life. The countdown is not applied to that cell.
- **Spawn and press on the same cell, same cycle.** The press sees the pre-spawn state, which is IDLE, so there is no effect. The spawn proceeds.
- **Terminal condition and further events in the cycle that sets it.** Events are fully applied. The FINISH transition is evaluated on the registered `life` and `score`.
- **Reset mid-game.** Reset immediately forces the reset values, regardless of state.

## Configuration
- `GAME_WARNING_EN` defined: fire spawns enter WARN for `WARN_TICKS` before becoming FIRE, and `warning_state` is driven.
- `GAME_WARNING_EN` undefined: fire spawns enter FIRE directly with countdown `FIRE_TICKS`. `warning_state` is tied to 9'h000 and `WARN_TICKS` is unused.

## Test plan
- **Reset and start.** Assert `rst`, release, pulse `start` → `game_state`=01, `life`=3, `score`=0, and all cell vectors are 0 on the next cycle.
- **Fire expiry.** Force a fire in cell 4 (grid state reached via a known seed), then send `FIRE_TICKS` ticks with no press → `fire_state[4]` clears and `life` goes from 3 to 2 on the same edge.
- **Gold collection.** Cell 0 is in GOLD; press idx 0 → `gold_state[0]`=0, `score`=1, `box`=9'h001. After 2 ticks, `box`=0.
- **Simultaneous events.** Press cell 2 on the same cycle its fire would expire → `life` is unchanged and `fire_state[2]`=0. Press idx 11 → no change anywhere.
- **Win and lose.** Collect 5 golds → `score`=5, then `game_state`=10 next cycle, and further presses change nothing. Let 3 fires expire → `life`=0, then FINISH. `start` → INIT with grid clear.
- **Macro check.** With `GAME_WARNING_EN`, a fire spawn shows `warning_state` for 3 ticks before `fire_state`. Without it, `fire_state` is set on the spawn tick and `warning_state` stays 0.
